// File: rtl/branch_predict_tracker.sv
// Tracks in-flight branches between fetch, the predictor and execute resolution.
// Optional statistics counters are enabled with the BP_TRACK_STAT_EN macro.
module branch_predict_tracker #(
  parameter int unsigned LOW_ADDR_WIDTH = 8,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              fetch_valid,
  input  logic [LOW_ADDR_WIDTH-1:0]         fetch_addr,
  output logic                              fetch_ready,
  output logic                              bp_predict_valid,
  output logic [LOW_ADDR_WIDTH-1:0]         bp_predict_addr,
  input  logic                              bp_predict_result,
  output logic                              pred_valid,
  output logic                              pred_taken,
  input  logic                              resolve_valid,
  input  logic                              resolve_taken,
  output logic                              resolve_ready,
  output logic                              bp_renew_valid,
  output logic [LOW_ADDR_WIDTH-1:0]         bp_renew_addr,
  output logic                              bp_last_predict,
  output logic                              bp_renew_result,
  output logic                              mispredict,
  output logic [$clog2(DEPTH):0]            inflight_count,
  output logic [15:0]                       stat_resolved,
  output logic [15:0]                       stat_mispredict
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_PRED = 2'd1,
    PREDICTED = 2'd2
  } entry_state_e;

  entry_state_e                           state_q [DEPTH];
  entry_state_e                           state_d [DEPTH];
  logic [DEPTH-1:0][LOW_ADDR_WIDTH-1:0]   addr_q;
  logic [DEPTH-1:0]                       pred_q;
  logic [PW-1:0]                          head_q, head_d;
  logic [PW-1:0]                          tail_q, tail_d;
  logic [CW-1:0]                          count_q, count_d;

  logic accept;
  logic resolve;
  logic flush;
  logic head_pred;
  logic wait_any;

  // Handshakes; a mispredicting resolve blocks fetch so nothing lands in a flushed slot.
  always_comb begin
    head_pred     = pred_q[head_q];
    resolve_ready = rst_n && (state_q[head_q] == PREDICTED);
    resolve       = resolve_valid && resolve_ready;
    flush         = resolve && (resolve_taken != head_pred);
    fetch_ready   = rst_n && (count_q < CW'(DEPTH)) && !flush;
    accept        = fetch_valid && fetch_ready;
    wait_any      = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (state_q[i] == WAIT_PRED) wait_any = 1'b1;
    end
  end

  assign bp_predict_valid = accept;
  assign bp_predict_addr  = fetch_addr;
  // The predictor answer is forwarded in the WAIT_PRED cycle unless that entry is being flushed.
  assign pred_valid       = wait_any && !flush;
  assign pred_taken       = pred_valid && bp_predict_result;
  assign inflight_count   = count_q;

  // Entry next-state and pointer bookkeeping
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      state_d[i] = state_q[i];
      if (state_q[i] == WAIT_PRED) state_d[i] = PREDICTED;
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (resolve) begin
      state_d[head_q] = EMPTY;
      head_d          = head_q + PW'(1);
    end
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) state_d[i] = EMPTY;
      tail_d  = head_q + PW'(1);
      count_d = '0;
    end else begin
      if (accept) begin
        state_d[tail_q] = WAIT_PRED;
        tail_d          = tail_q + PW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(resolve);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) state_q[i] <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) state_q[i] <= state_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload: address on accept, prediction during WAIT_PRED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      pred_q <= '0;
    end else begin
      if (accept) addr_q[tail_q] <= fetch_addr;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (state_q[i] == WAIT_PRED) pred_q[i] <= bp_predict_result;
      end
    end
  end

  // Predictor update and mispredict pulse, one cycle after resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_renew_valid  <= 1'b0;
      bp_renew_addr   <= '0;
      bp_last_predict <= 1'b0;
      bp_renew_result <= 1'b0;
      mispredict      <= 1'b0;
    end else begin
      bp_renew_valid <= resolve;
      mispredict     <= flush;
      if (resolve) begin
        bp_renew_addr   <= addr_q[head_q];
        bp_last_predict <= head_pred;
        bp_renew_result <= resolve_taken;
      end
    end
  end

`ifdef BP_TRACK_STAT_EN
  // Saturating resolve / mispredict counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (resolve && (stat_resolved != 16'hFFFF)) stat_resolved <= stat_resolved + 16'd1;
      if (flush && (stat_mispredict != 16'hFFFF)) stat_mispredict <= stat_mispredict + 16'd1;
    end
  end
`else
  assign stat_resolved   = 16'd0;
  assign stat_mispredict = 16'd0;
`endif

endmodule

// File: doc/branch_predict_tracker.md
BRANCH_PREDICT_TRACKER -- requirements
Module: branch_predict_tracker

Interface
REQ-001 Parameter LOW_ADDR_WIDTH, default 8: width of the branch low-address index.
REQ-002 Parameter DEPTH, default 4: in-flight branch entries; power of two, minimum 2.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 fetch_valid  in  1  fetch presents a branch needing prediction.
REQ-006 fetch_addr  in  LOW_ADDR_WIDTH  branch low address.
REQ-007 fetch_ready  out  1  tracker can accept a branch this cycle.
REQ-008 bp_predict_valid / bp_predict_addr  out  1 / LOW_ADDR_WIDTH  predictor lookup request.
REQ-009 bp_predict_result  in  1  predictor registered result, valid the cycle after bp_predict_valid.
REQ-010 pred_valid / pred_taken  out  1 / 1  prediction returned to fetch.
REQ-011 resolve_valid / resolve_taken  in  1 / 1  execute resolves the oldest in-flight branch.
REQ-012 resolve_ready  out  1  oldest entry holds a prediction and can be resolved.
REQ-013 bp_renew_valid, bp_last_predict, bp_renew_result  out  1 each; bp_renew_addr  out  LOW_ADDR_WIDTH  predictor update.
REQ-014 mispredict  out  1  one-cycle pulse on wrong prediction.
REQ-015 inflight_count  out  clog2(DEPTH)+1  occupied entries.
REQ-016 stat_resolved, stat_mispredict  out  16 each  statistics counters (REQ-034).

Function
REQ-017 Accept = fetch_valid && fetch_ready; resolve = resolve_valid && resolve_ready.
REQ-018 fetch_ready = (inflight_count < DEPTH) && !(resolve && resolve_taken != head prediction); combinational, no same-cycle slot reuse when full.
REQ-019 bp_predict_valid = accept; bp_predict_addr = fetch_addr; both combinational.
REQ-020 Entry states: EMPTY -> WAIT_PRED on accept (address stored, tail++) -> PREDICTED the next cycle (bp_predict_result stored) -> EMPTY on resolve (head++).
REQ-021 pred_valid pulses exactly one cycle after accept, pred_taken = bp_predict_result, unless the entry was flushed (REQ-025).
REQ-022 resolve_ready = head entry in PREDICTED; resolve_valid while not ready is ignored with no state change.
REQ-023 One cycle after resolve: bp_renew_valid=1, bp_renew_addr = entry address, bp_last_predict = stored prediction, bp_renew_result = resolve_taken; all other cycles bp_renew_valid=0, other renew fields hold.
REQ-024 One cycle after a resolve with resolve_taken != stored prediction: mispredict=1 for one cycle.
REQ-025 Mispredicting resolve flushes all younger entries at the same edge (tail = head+1 mod DEPTH, count = 0); a younger WAIT_PRED entry's result is discarded and its pred_valid suppressed.
REQ-026 Simultaneous accept and correct resolve: count unchanged, both pointers advance.
REQ-027 Head/tail pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.

Reset
REQ-028 rst_n low asynchronously clears all entries to EMPTY, pointers and inflight_count to 0.
REQ-029 During reset: fetch_ready=0, resolve_ready=0, pred_valid=0, pred_taken=0, bp_renew_* = 0, mispredict=0, stat counters = 0.
REQ-030 Reset mid-operation discards in-flight entries; no pred_valid or bp_renew_valid is issued for them afterwards.
REQ-031 fetch_ready is 1 in the first cycle after reset release.

Configuration
REQ-032 Macro BP_TRACK_STAT_EN selects statistics logic.
REQ-033 Without BP_TRACK_STAT_EN: stat_resolved and stat_mispredict are tied to 0, no counter flops.
REQ-034 With BP_TRACK_STAT_EN: stat_resolved increments per resolve, stat_mispredict per mispredicting resolve, both saturating at 16'hFFFF, updated the cycle after resolve.

Verification
REQ-035 Reset, accept addr 8'h3C, bp_predict_result=1 -> bp_predict_addr=8'h3C same cycle; pred_valid=1, pred_taken=1 next cycle; inflight_count=1.
REQ-036 Resolve that entry with resolve_taken=1 -> next cycle bp_renew_valid=1, addr 8'h3C, last_predict=1, result=1, mispredict=0; count=0.
REQ-037 Fill 4 entries (DEPTH=4) -> fetch_ready=0; resolve head correctly while fetch_valid=1 -> no accept that cycle, accept next cycle, tail wraps to 1.
REQ-038 Three entries predicted 0, resolve head with resolve_taken=1 -> mispredict pulse, renew result=1 last_predict=0, inflight_count=0, no further pred_valid or renew.
REQ-039 Accept entry then assert resolve_valid in the WAIT_PRED cycle -> resolve_ready=0, ignored; resolve accepted one cycle later.
REQ-040 With BP_TRACK_STAT_EN: 3 resolves, 1 mispredicting -> stat_resolved=3, stat_mispredict=1; rst_n pulse mid-stream -> all counters and outputs 0.
